aes_key_sched_ctrl: RTL

- Iterative controller for AES-128 key expansion. Owns a single round-key step datapath (the `round_key` module) and sequences it over 10 cycles, one round key per cycle.
- Stores all 11 round keys (key0..key10) in an internal register file.
- Serves any stored key by index to the decryption round engine, which reads them in reverse order (10 down to 0).
- Replaces the fully unrolled 10-instance expansion, trading latency for area.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/round_key.sv | 28 ++
 rtl/aes_key_sched_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, state encoding, key type and GF(2^8) helpers.
// The helpers are also used by the InvMixColumns logic.
package aes_pkg;

    localparam int unsigned NR    = 10;
    localparam int unsigned KEY_W = 128;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef logic [KEY_W-1:0] key_t;

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // S-box as multiplicative inverse (a^254, 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] t2, t3, t6, t7, t14, t15, t30, t31, t62, t63, t126, t127, inv;
        t2   = gf_mul(a, a);
        t3   = gf_mul(t2, a);
        t6   = gf_mul(t3, t3);
        t7   = gf_mul(t6, a);
        t14  = gf_mul(t7, t7);
        t15  = gf_mul(t14, a);
        t30  = gf_mul(t15, t15);
        t31  = gf_mul(t30, a);
        t62  = gf_mul(t31, t31);
        t63  = gf_mul(t62, a);
        t126 = gf_mul(t63, t63);
        t127 = gf_mul(t126, a);
        inv  = gf_mul(t127, t127);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/round_key.sv
// One AES-128 key expansion step: derives the next round key from the previous one.
module round_key
    import aes_pkg::*;
(
    input  key_t        i_key,
    input  logic [31:0] i_rcon,
    output key_t        o_key_c
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0 = i_key[127:96];
    assign w_w1 = i_key[95:64];
    assign w_w2 = i_key[63:32];
    assign w_w3 = i_key[31:0];

    assign w_temp = sub_word({w_w3[23:0], w_w3[31:24]}) ^ i_rcon;

    assign w_n0 = w_w0 ^ w_temp;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_key_c = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule: one round_key step per cycle into an 11-entry key file,
// with a combinational read port for the decryption engine.
module aes_key_sched_ctrl #(
    parameter int unsigned NR    = 10,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [127:0]     key_in,
    output logic             busy,
    output logic             keys_valid,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [127:0]     rd_key
);
    import aes_pkg::key_t;
    import aes_pkg::state_t;
    import aes_pkg::IDLE;
    import aes_pkg::EXPAND;
    import aes_pkg::RCON_INIT;
    import aes_pkg::xtime;

    localparam int unsigned NKEYS = NR + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_start;
    logic             w_step;
    logic             w_last;
    logic [IDX_W-1:0] r_cnt;
    logic [7:0]       r_rcon;
    key_t             r_slot [NKEYS];
    key_t             w_prev;
    key_t             w_next;
    logic             r_busy;
    logic             r_keys_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_start     = 1'b1;
                    w_state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                w_step = 1'b1;
                if (r_cnt == IDX_W'(NR)) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Step input is always the registered previous slot, never key_in.
    always_comb begin
        w_prev = '0;
        for (int i = 0; i < int'(NR); i++) begin
            if (r_cnt == IDX_W'(i + 1)) w_prev = r_slot[i];
        end
    end

    round_key u_round_key (
        .i_key   (w_prev),
        .i_rcon  ({r_rcon, 24'h0}),
        .o_key_c (w_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_rcon       <= RCON_INIT;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b0;
            for (int i = 0; i < int'(NKEYS); i++) r_slot[i] <= '0;
        end else if (w_start) begin
            r_slot[0]    <= key_in;
            r_cnt        <= IDX_W'(1);
            r_rcon       <= RCON_INIT;
            r_busy       <= 1'b1;
            r_keys_valid <= 1'b0;
        end else if (w_step) begin
            for (int i = 1; i < int'(NKEYS); i++) begin
                if (r_cnt == IDX_W'(i)) r_slot[i] <= w_next;
            end
            r_cnt  <= r_cnt + IDX_W'(1);
            r_rcon <= xtime(r_rcon);
            if (w_last) begin
                r_busy       <= 1'b0;
                r_keys_valid <= 1'b1;
            end
        end
    end

    // Indices beyond the last round key read as zero.
    always_comb begin
        rd_key = '0;
        for (int i = 0; i < int'(NKEYS); i++) begin
            if (rd_idx == IDX_W'(i)) rd_key = r_slot[i];
        end
    end

    assign busy       = r_busy;
    assign keys_valid = r_keys_valid;

endmodule
